// File: rtl/shape_scan_sequencer.sv
// shape_scan_sequencer
//   Takes one shape command (origin, size, colour, program). It walks the bounding box
//   row-major and emits one pixel per cycle on a valid/ready stream to the output stage.
//   Optional feature macro: SHAPE_SCAN_CLIP_EN. When it is defined, positions outside
//   SCREEN_W x SCREEN_H are skipped.
//
//   Handshakes: a transfer happens on a rising edge where valid & ready are both high.
//   Once pix_valid is raised it stays high, and pix_* hold stable, until pix_ready
//   accepts the pixel. Only reset can drop it earlier. cmd_ready is high only in IDLE.
module shape_scan_sequencer #(
    parameter int X_W      = 11,
    parameter int Y_W      = 12,
    parameter int COLOR_W  = 32,
    parameter int PROG_W   = 6,
    parameter int SCREEN_W = 1920,
    parameter int SCREEN_H = 1080
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [X_W-1:0]     cmd_x,
    input  logic [Y_W-1:0]     cmd_y,
    input  logic [X_W-1:0]     cmd_width,
    input  logic [Y_W-1:0]     cmd_height,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic [PROG_W-1:0]  cmd_program,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_W-1:0]     pix_x,
    output logic [Y_W-1:0]     pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic [PROG_W-1:0]  pix_program,
    output logic               pix_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [X_W-1:0]     org_x, wid, cx;
    logic [Y_W-1:0]     org_y, hgt, cy;
    logic [COLOR_W-1:0] color_q;
    logic [PROG_W-1:0]  prog_q;

    logic cmd_fire;
    logic last_col, last_row, at_end;
    logic clipped, advance;

    // A screen that does not fit the coordinate range makes the clip compare meaningless.
    if (SCREEN_W < 1 || SCREEN_W > (1 << X_W) || SCREEN_H < 1 || SCREEN_H > (1 << Y_W)) begin : g_bad_screen
        $error("shape_scan_sequencer: SCREEN_W/SCREEN_H outside coordinate range");
    end

    assign cmd_fire = cmd_valid & cmd_ready;
    assign last_col = (cx == wid - X_W'(1));
    assign last_row = (cy == hgt - Y_W'(1));
    assign at_end   = last_col & last_row;

`ifdef SHAPE_SCAN_CLIP_EN
    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;

    // The sum is one bit wider so that positions past the screen edge do not wrap back onto it.
    assign sum_x   = {1'b0, org_x} + {1'b0, cx};
    assign sum_y   = {1'b0, org_y} + {1'b0, cy};
    assign clipped = (sum_x >= SCR_W) || (sum_y >= SCR_H);
    assign pix_x   = sum_x[X_W-1:0];
    assign pix_y   = sum_y[Y_W-1:0];
`else
    assign clipped = 1'b0;
    assign pix_x   = org_x + cx;
    assign pix_y   = org_y + cy;
`endif

    // A clipped position costs one cycle with no transfer. The counters still step.
    assign pix_valid   = (state == SCAN) & ~clipped;
    assign advance     = (state == SCAN) & (clipped | pix_ready);
    assign pix_last    = pix_valid & at_end;
    assign pix_color   = color_q;
    assign pix_program = prog_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and control outputs
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_width == '0 || cmd_height == '0) state_nxt = FIN;
                    else                                     state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (advance && at_end) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch and raster counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            org_x   <= '0;
            org_y   <= '0;
            wid     <= '0;
            hgt     <= '0;
            color_q <= '0;
            prog_q  <= '0;
            cx      <= '0;
            cy      <= '0;
        end else if (cmd_fire) begin
            org_x   <= cmd_x;
            org_y   <= cmd_y;
            wid     <= cmd_width;
            hgt     <= cmd_height;
            color_q <= cmd_color;
            prog_q  <= cmd_program;
            cx      <= '0;
            cy      <= '0;
        end else if (advance) begin
            if (last_col) begin
                cx <= '0;
                cy <= cy + Y_W'(1);
            end else begin
                cx <= cx + X_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shape_scan_sequencer.sv
// Bench for shape_scan_sequencer: a command table, randomized commands and hand-written
// corner sequences. The expected pixels come from a raster-walk reference model.
module tb_shape_scan_sequencer;

    localparam int X_W     = 11;
    localparam int Y_W     = 12;
    localparam int COLOR_W = 32;
    localparam int PROG_W  = 6;
    localparam int PW      = X_W + Y_W + COLOR_W + PROG_W + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [X_W-1:0]     cmd_x = '0;
    logic [Y_W-1:0]     cmd_y = '0;
    logic [X_W-1:0]     cmd_width = '0;
    logic [Y_W-1:0]     cmd_height = '0;
    logic [COLOR_W-1:0] cmd_color = '0;
    logic [PROG_W-1:0]  cmd_program = '0;
    logic               pix_valid;
    logic               pix_ready = 1'b0;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic [PROG_W-1:0]  pix_program;
    logic               pix_last;
    logic               busy;
    logic               done;

    shape_scan_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_width(cmd_width), .cmd_height(cmd_height),
        .cmd_color(cmd_color), .cmd_program(cmd_program),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_program(pix_program),
        .pix_last(pix_last), .busy(busy), .done(done)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        int           x;
        int           y;
        int           w;
        int           h;
        logic [31:0]  color;
        logic [5:0]   prog;
    } cmd_t;

    typedef struct {
        cmd_t c;
        int   mode;        // 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
        int   pix_noclip;  // pixels expected without clipping
        int   pix_clip;    // pixels expected with clipping
    } vec_t;

    logic [PW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: walk the box with plain integers and keep the positions that land on
    // screen. Coordinates wrap at the port width.
    function automatic int build_expected(input cmd_t c);
        int n;
        int sx, sy;
        logic [X_W-1:0] ex;
        logic [Y_W-1:0] ey;
        logic lst;
        n = 0;
        for (int r = 0; r < c.h; r++) begin
            for (int k = 0; k < c.w; k++) begin
                sx = c.x + k;
                sy = c.y + r;
`ifdef SHAPE_SCAN_CLIP_EN
                if (sx >= 1920 || sy >= 1080) continue;
`endif
                ex  = X_W'(sx % (1 << X_W));
                ey  = Y_W'(sy % (1 << Y_W));
                lst = (r == c.h - 1) && (k == c.w - 1);
                exp_q.push_back({ex, ey, c.color, c.prog, lst});
                n++;
            end
        end
        return n;
    endfunction

    task automatic drive_cmd(input cmd_t c);
        cmd_x       = X_W'(c.x);
        cmd_y       = Y_W'(c.y);
        cmd_width   = X_W'(c.w);
        cmd_height  = Y_W'(c.h);
        cmd_color   = c.color;
        cmd_program = c.prog;
    endtask

    // Present a command and wait until the handshake is due on the next rising edge
    task automatic issue_cmd(input cmd_t c);
        int guard;
        @(negedge clk);
        drive_cmd(c);
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout actual=0 expected=1");
        end
    endtask

    // Follow one command from handshake to done. If chain is set, the next command is left
    // waiting on the bus with cmd_valid still high.
    task automatic scan(input cmd_t c, input int mode, input bit chain, input cmd_t nxt,
                        output int n_pix, output int exp_n);
        int cyc, busy_cnt, budget;
        bit got_done, held;
        logic [PW-1:0] hold_v, obs;
        n_pix = 0;
        busy_cnt = 0;
        got_done = 1'b0;
        held = 1'b0;
        hold_v = '0;
        cyc = 0;
        budget = c.w * c.h * 8 + 40;
        exp_n = build_expected(c);
        while (!got_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (chain) drive_cmd(nxt);
                else       cmd_valid = 1'b0;
            end
            obs = {pix_x, pix_y, pix_color, pix_program, pix_last};
            if (held) begin
                check("stall_hold", {63'(obs), pix_valid}, {63'(hold_v), 1'b1});
                held = 1'b0;
            end
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (cyc % 3 == 1);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (busy) busy_cnt++;
            if (done) begin
                got_done = 1'b1;
                check("fin_outputs", {61'd0, pix_valid, busy, cmd_ready}, 64'd0);
            end else if (pix_valid && pix_ready) begin
                n_pix++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_pixel actual=%h expected=none", obs);
                end else begin
                    check("pixel", 64'(obs), 64'(exp_q.pop_front()));
                end
            end else if (pix_valid) begin
                held = 1'b1;
                hold_v = obs;
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 expected=1");
        end
        check("missing_pixels", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (mode == 0) begin
            check("done_cycle", 64'(cyc), 64'(c.w * c.h + 1));
            check("busy_cycles", 64'(busy_cnt), 64'(c.w * c.h));
        end
        @(negedge clk);
        check("after_done", {62'd0, done, cmd_ready}, 64'd1);
    endtask

    vec_t vecs[10];
    cmd_t c, c2, none;
    int n_pix, exp_n, cnt, guard;
    bit seen;

    initial begin
        vecs[0] = '{c: '{x: 10, y: 20, w: 3, h: 2, color: 32'h1234_5678, prog: 6'h05}, mode: 0, pix_noclip: 6, pix_clip: 6};
        vecs[1] = '{c: '{x: 10, y: 20, w: 3, h: 2, color: 32'hDEAD_BEEF, prog: 6'h2A}, mode: 1, pix_noclip: 6, pix_clip: 6};
        vecs[2] = '{c: '{x: 3, y: 7, w: 0, h: 5, color: 32'h1, prog: 6'h1}, mode: 0, pix_noclip: 0, pix_clip: 0};
        vecs[3] = '{c: '{x: 0, y: 0, w: 1, h: 1, color: 32'hCAFE_0001, prog: 6'h3F}, mode: 0, pix_noclip: 1, pix_clip: 1};
        vecs[4] = '{c: '{x: 1918, y: 1079, w: 4, h: 2, color: 32'h0BAD_F00D, prog: 6'h11}, mode: 0, pix_noclip: 8, pix_clip: 2};
        vecs[5] = '{c: '{x: 2046, y: 4094, w: 3, h: 3, color: 32'h5555_AAAA, prog: 6'h22}, mode: 2, pix_noclip: 9, pix_clip: 0};
        vecs[6] = '{c: '{x: 1900, y: 1070, w: 5, h: 4, color: 32'hFFFF_0000, prog: 6'h0C}, mode: 1, pix_noclip: 20, pix_clip: 20};
        vecs[7] = '{c: '{x: 100, y: 200, w: 4, h: 0, color: 32'h7, prog: 6'h7}, mode: 0, pix_noclip: 0, pix_clip: 0};
        vecs[8] = '{c: '{x: 0, y: 0, w: 2047, h: 1, color: 32'hA5A5_5A5A, prog: 6'h15}, mode: 0, pix_noclip: 2047, pix_clip: 1920};
        vecs[9] = '{c: '{x: 5, y: 0, w: 1, h: 4095, color: 32'h0F0F_F0F0, prog: 6'h2B}, mode: 0, pix_noclip: 4095, pix_clip: 1080};
        none = '{x: 0, y: 0, w: 0, h: 0, color: 32'h0, prog: 6'h0};

        // Reset
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs",
              64'({pix_valid, busy, done, pix_last, pix_x, pix_y, pix_color, pix_program}), 64'd0);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Command table
        for (int i = 0; i < 10; i++) begin
            issue_cmd(vecs[i].c);
            scan(vecs[i].c, vecs[i].mode, 1'b0, none, n_pix, exp_n);
`ifdef SHAPE_SCAN_CLIP_EN
            check("table_count", 64'(n_pix), 64'(vecs[i].pix_clip));
`else
            check("table_count", 64'(n_pix), 64'(vecs[i].pix_noclip));
`endif
        end

        // Back-to-back: the second command waits with cmd_valid high during the first
        c  = '{x: 10, y: 20, w: 3, h: 2, color: 32'h1111_2222, prog: 6'h01};
        c2 = '{x: 40, y: 50, w: 2, h: 2, color: 32'h3333_4444, prog: 6'h02};
        issue_cmd(c);
        scan(c, 0, 1'b1, c2, n_pix, exp_n);
        scan(c2, 0, 1'b0, none, n_pix, exp_n);
        check("b2b_count", 64'(n_pix), 64'd4);

        // Reset mid-scan after 4 of 12 pixels
        c = '{x: 0, y: 0, w: 4, h: 3, color: 32'h9999_9999, prog: 6'h09};
        issue_cmd(c);
        pix_ready = 1'b1;
        cnt = 0;
        guard = 0;
        while (cnt < 4 && guard < 50) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (pix_valid) cnt++;
            guard++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midscan_reset_outputs",
              64'({pix_valid, busy, done, pix_last, pix_x, pix_y, pix_color, pix_program}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || pix_valid || !cmd_ready) seen = 1'b1;
        end
        check("after_reset_idle", 64'(seen), 64'd0);
        c = '{x: 5, y: 5, w: 2, h: 1, color: 32'h0000_00FF, prog: 6'h03};
        issue_cmd(c);
        scan(c, 0, 1'b0, none, n_pix, exp_n);
        check("post_reset_count", 64'(n_pix), 64'd2);

        // Randomized commands, often placed near the screen and coordinate edges
        for (int i = 0; i < 30; i++) begin
            c.x = ($urandom_range(0, 2) == 0) ? $urandom_range(1910, 2047) : $urandom_range(0, 2047);
            c.y = ($urandom_range(0, 2) == 0) ? $urandom_range(1074, 1085)
                : (($urandom_range(0, 4) == 0) ? $urandom_range(4090, 4095) : $urandom_range(0, 4095));
            c.w = $urandom_range(0, 6);
            c.h = $urandom_range(0, 5);
            c.color = $urandom;
            c.prog = 6'($urandom_range(0, 63));
            issue_cmd(c);
            scan(c, $urandom_range(0, 2), 1'b0, none, n_pix, exp_n);
            check("rand_count", 64'(n_pix), 64'(exp_n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
